conv_acc_relu_sat: RTL and testbench

- Downstream consumer of the conv2 signed 14x8 product stage.
- Accepts a stream of 23-bit signed products, one per handshake.
- Sums NUM_TERMS products plus a per-output bias.
- Rescales, applies ReLU, saturates to the activation width, and emits one result per window with valid/ready flow control toward the pooling/activation buffer.

---
 rtl/conv_acc_relu_sat.sv | 128 ++++++++++++
 tb/tb_conv_acc_relu_sat.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_acc_relu_sat.sv
// Window accumulator for conv2 products: bias + NUM_TERMS products, arithmetic shift, optional ReLU, saturate.
// Optional feature macro: CONV_ACC_RELU_EN (defined = clamp negative shifted sums to zero).
module conv_acc_relu_sat #(
    parameter int PROD_WIDTH = 23,
    parameter int BIAS_WIDTH = 23,
    parameter int ACC_WIDTH  = 32,
    parameter int NUM_TERMS  = 25,
    parameter int OUT_SHIFT  = 4,
    parameter int OUT_WIDTH  = 14
) (
    input  logic                             ap_clk,
    input  logic                             ap_rst,
    input  logic [PROD_WIDTH-1:0]            prod_data,
    input  logic                             prod_valid,
    output logic                             prod_ready,
    input  logic [BIAS_WIDTH-1:0]            bias_data,
    output logic [OUT_WIDTH-1:0]             out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [$clog2(NUM_TERMS+1)-1:0]   term_cnt
);

    localparam int CNT_W = $clog2(NUM_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(NUM_TERMS - 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = ACC_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ACC_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

    // Width too small for the worst-case window sum is rejected at elaboration.
    if (ACC_WIDTH < PROD_WIDTH + $clog2(NUM_TERMS) + 1) begin : g_acc_width_check
        $error("conv_acc_relu_sat: ACC_WIDTH too small for NUM_TERMS products");
    end

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_OUT   = 1'b1
    } state_t;

    state_t                        state_r;
    logic signed [ACC_WIDTH-1:0]   acc_r;
    logic        [CNT_W-1:0]       cnt_r;
    logic        [OUT_WIDTH-1:0]   out_data_r;
    logic                          out_valid_r;

    logic signed [ACC_WIDTH-1:0]   prod_ext_s;
    logic signed [ACC_WIDTH-1:0]   bias_ext_s;
    logic signed [ACC_WIDTH-1:0]   acc_next_s;
    logic signed [ACC_WIDTH-1:0]   shifted_s;

    function automatic logic [OUT_WIDTH-1:0] sat_act(input logic signed [ACC_WIDTH-1:0] v);
        logic [OUT_WIDTH-1:0] r;
`ifdef CONV_ACC_RELU_EN
        if (v[ACC_WIDTH-1]) begin
            r = '0;
        end else if (v > OUT_MAX) begin
            r = OUT_MAX[OUT_WIDTH-1:0];
        end else begin
            r = v[OUT_WIDTH-1:0];
        end
`else
        if (v > OUT_MAX) begin
            r = OUT_MAX[OUT_WIDTH-1:0];
        end else if (v < OUT_MIN) begin
            r = OUT_MIN[OUT_WIDTH-1:0];
        end else begin
            r = v[OUT_WIDTH-1:0];
        end
`endif
        return r;
    endfunction

    assign prod_ext_s = {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
    assign bias_ext_s = {{(ACC_WIDTH-BIAS_WIDTH){bias_data[BIAS_WIDTH-1]}}, bias_data};
    assign shifted_s  = acc_next_s >>> OUT_SHIFT;

    assign prod_ready = (state_r == ST_ACCUM);
    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign term_cnt   = cnt_r;

    // Next accumulator value: the first product of a window starts from the bias.
    always_comb begin
        acc_next_s = acc_r;
        if (cnt_r == '0) begin
            acc_next_s = bias_ext_s + prod_ext_s;
        end else begin
            acc_next_s = acc_r + prod_ext_s;
        end
    end

    // Window control, accumulation and registered result handshake.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r     <= ST_ACCUM;
            acc_r       <= '0;
            cnt_r       <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_ACCUM: begin
                    if (prod_valid) begin
                        acc_r <= acc_next_s;
                        if (cnt_r == LAST_TERM) begin
                            cnt_r       <= '0;
                            out_data_r  <= sat_act(shifted_s);
                            out_valid_r <= 1'b1;
                            state_r     <= ST_OUT;
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_ACCUM;
                    end
                end
                default: begin
                    state_r     <= ST_ACCUM;
                    out_valid_r <= 1'b0;
                    cnt_r       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_acc_relu_sat.sv
// Self-checking bench for conv_acc_relu_sat (NUM_TERMS=4); honours CONV_ACC_RELU_EN when defined.
module tb_conv_acc_relu_sat;

    localparam int PW = 23;
    localparam int BW = 23;
    localparam int AW = 32;
    localparam int NT = 4;
    localparam int OS = 4;
    localparam int OW = 14;
    localparam int CW = $clog2(NT + 1);

    logic                 ap_clk = 1'b0;
    logic                 ap_rst;
    logic signed [PW-1:0] prod_data;
    logic                 prod_valid;
    logic                 prod_ready;
    logic signed [BW-1:0] bias_data;
    logic [OW-1:0]        out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [CW-1:0]        term_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    logic signed [PW-1:0] win_prod [NT];

    conv_acc_relu_sat #(
        .PROD_WIDTH(PW), .BIAS_WIDTH(BW), .ACC_WIDTH(AW),
        .NUM_TERMS(NT), .OUT_SHIFT(OS), .OUT_WIDTH(OW)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .prod_data(prod_data), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .bias_data(bias_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .term_cnt(term_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    // Reference: exact sum, floor division by 2^OS, optional ReLU, clamp.
    function automatic longint model_out(input longint bias);
        longint s;
        longint q;
        longint hi;
        s = bias;
        for (int i = 0; i < NT; i++) s += longint'(win_prod[i]);
        q = s / (longint'(1) << OS);
        if ((s % (longint'(1) << OS)) != 0 && s < 0) q = q - 1;
`ifdef CONV_ACC_RELU_EN
        if (q < 0) q = 0;
`endif
        hi = (longint'(1) << (OW - 1)) - 1;
        if (q > hi) q = hi;
        if (q < -hi - 1) q = -hi - 1;
        return q;
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Offers the NT products in win_prod; reports early valid, count trace errors and result.
    task automatic drive_window(input logic signed [BW-1:0] b, input bit gaps,
                                output bit timed_out, output bit early, output bit cnt_bad,
                                output bit valid_seen, output longint obs);
        int guard;
        timed_out = 1'b0;
        early     = 1'b0;
        cnt_bad   = 1'b0;
        for (int i = 0; i < NT; i++) begin
            if (gaps) begin
                prod_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
                if (term_cnt !== CW'(i)) cnt_bad = 1'b1;
            end
            prod_valid = 1'b1;
            prod_data  = win_prod[i];
            bias_data  = (i == 0) ? b : BW'($urandom);
            guard = 0;
            while (prod_ready !== 1'b1 && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) timed_out = 1'b1;
            tick();
            if (i < NT - 1) begin
                if (out_valid !== 1'b0) early = 1'b1;
                if (term_cnt !== CW'(i + 1)) cnt_bad = 1'b1;
            end
        end
        prod_valid = 1'b0;
        prod_data  = PW'($urandom);
        valid_seen = out_valid;
        obs        = longint'($signed(out_data));
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        ap_rst = 1'b1; prod_valid = 1'b1; prod_data = 23'sd77; bias_data = 23'sd5; out_ready = 1'b0;
        repeat (2) tick();
        ap_rst = 1'b0; prod_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 14'd0) begin n_fail++; $display("FAIL reset_out_data got %0d want 0", out_data); end
        n_cmp++; if (term_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_term_cnt got %0d want 0", term_cnt); end
        n_cmp++; if (prod_ready !== 1'b1) begin n_fail++; $display("FAIL reset_prod_ready got %0b want 1", prod_ready); end
    endtask

    task automatic run_directed(input string name, input logic signed [BW-1:0] b, input bit gaps,
                                input longint want);
        bit to, early, cb, vs;
        longint obs;
        drive_window(b, gaps, to, early, cb, vs, obs);
        n_cmp++; if (to) begin n_fail++; $display("FAIL %s_timeout got stalled want accepted", name); end
        n_cmp++; if (early) begin n_fail++; $display("FAIL %s_early_valid got 1 want 0", name); end
        n_cmp++; if (cb) begin n_fail++; $display("FAIL %s_term_cnt got bad trace want 0..%0d", name, NT - 1); end
        n_cmp++; if (vs !== 1'b1) begin n_fail++; $display("FAIL %s_latency got out_valid=%0b want 1", name, vs); end
        n_cmp++; if (obs !== want) begin n_fail++; $display("FAIL %s_data got %0d want %0d", name, obs, want); end
        consume();
    endtask

    task automatic test_sum_shift();
        win_prod[0] = 23'sd100; win_prod[1] = 23'sd200; win_prod[2] = 23'sd300; win_prod[3] = 23'sd400;
        run_directed("sum_shift", 23'sd10, 1'b0, 64'sd63);
    endtask

    task automatic test_negative();
        longint want;
`ifdef CONV_ACC_RELU_EN
        want = 0;
`else
        want = -250;
`endif
        for (int i = 0; i < NT; i++) win_prod[i] = -23'sd1000;
        run_directed("negative", 23'sd0, 1'b0, want);
    endtask

    task automatic test_saturation();
        longint want;
        for (int i = 0; i < NT; i++) win_prod[i] = 23'sd4000000;
        run_directed("sat_pos", 23'sd0, 1'b0, 64'sd8191);
`ifdef CONV_ACC_RELU_EN
        want = 0;
`else
        want = -8192;
`endif
        for (int i = 0; i < NT; i++) win_prod[i] = -23'sd4000000;
        run_directed("sat_neg", 23'sd0, 1'b0, want);
    endtask

    task automatic test_backpressure();
        bit to, early, cb, vs;
        longint obs;
        logic [OW-1:0] held;
        for (int i = 0; i < NT; i++) win_prod[i] = 23'sd320;
        drive_window(23'sd0, 1'b0, to, early, cb, vs, obs);
        held = out_data;
        n_cmp++; if (obs !== 64'sd80) begin n_fail++; $display("FAIL bp_data got %0d want 80", obs); end
        prod_valid = 1'b1; prod_data = 23'sd9999;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid cyc %0d got %0b want 1", c, out_valid); end
            n_cmp++; if (out_data !== held) begin n_fail++; $display("FAIL bp_hold_data cyc %0d got %0d want %0d", c, out_data, held); end
            n_cmp++; if (prod_ready !== 1'b0) begin n_fail++; $display("FAIL bp_prod_ready cyc %0d got %0b want 0", c, prod_ready); end
            n_cmp++; if (term_cnt !== 3'd0) begin n_fail++; $display("FAIL bp_no_consume cyc %0d got %0d want 0", c, term_cnt); end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; prod_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %0b want 0", out_valid); end
        n_cmp++; if (prod_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %0b want 1", prod_ready); end
        n_cmp++; if (term_cnt !== 3'd0) begin n_fail++; $display("FAIL bp_release_cnt got %0d want 0", term_cnt); end
    endtask

    task automatic test_reset_mid_window();
        prod_valid = 1'b1; prod_data = 23'sd500; bias_data = 23'sd0;
        tick(); tick();
        n_cmp++; if (term_cnt !== 3'd2) begin n_fail++; $display("FAIL mid_pre_reset_cnt got %0d want 2", term_cnt); end
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0; prod_valid = 1'b0;
        n_cmp++; if (term_cnt !== 3'd0) begin n_fail++; $display("FAIL mid_reset_cnt got %0d want 0", term_cnt); end
        for (int i = 0; i < NT; i++) win_prod[i] = 23'sd16;
        run_directed("mid_reset", 23'sd0, 1'b1, 64'sd4);
    endtask

    task automatic test_random();
        logic signed [BW-1:0] b;
        for (int w = 0; w < 12; w++) begin
            for (int i = 0; i < NT; i++) begin
                if (w % 2 == 0) win_prod[i] = PW'($urandom);
                else win_prod[i] = PW'($urandom_range(0, 4000)) - 23'sd2000;
            end
            b = (w % 2 == 0) ? BW'($urandom) : BW'($urandom_range(0, 200)) - 23'sd100;
            run_directed("random", b, w[1:0] == 2'd3, model_out(longint'(b)));
        end
    endtask

    initial begin
        test_reset();
        test_sum_shift();
        test_negative();
        test_saturation();
        test_backpressure();
        test_reset_mid_window();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
